// File: rtl/clk_div_sched_if.sv
// Ratio-change handshake between the requesters and the shared divider controller.
interface clk_div_sched_if #(
    parameter int N_REQ = 4,
    parameter int DIV_W = 8
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*DIV_W-1:0] div_val;
    logic [N_REQ-1:0]       grant;
    logic [N_REQ-1:0]       ack;
    logic                   err;

    modport master (output req, output div_val, input grant, input ack, input err);
    modport slave  (input req, input div_val, output grant, output ack, output err);
endinterface

// File: rtl/clk_div_sched.sv
// clk_div_sched: programmable divider shared round-robin by N_REQ requesters; CLK_DIV_SCHED_GATE_EN adds clk_en gating.
// Latency: grant 1 cycle after req; ack 2..div_active+1 cycles after grant.
// Backpressure: requesters hold req until ack; new ratios only load at a divider period boundary.
module clk_div_sched #(
    parameter int N_REQ       = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk_in,
    input  logic             rst_n,
`ifdef CLK_DIV_SCHED_GATE_EN
    input  logic             clk_en,
`endif
    clk_div_sched_if.slave   bus,
    output logic             busy,
    output logic [DIV_W-1:0] div_active,
    output logic             clk_out
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WAIT} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] rr_ptr, rr_nxt, sel, sel_nxt, sel_inc, pick;
    logic             pick_vld;
    logic [DIV_W-1:0] pend, pend_nxt, cnt, cnt_nxt, hi_len;
    logic [N_REQ-1:0] masked, grant_nxt, ack_nxt;
    logic             err_nxt, boundary, load;

    // ---------------- divider ----------------
    assign hi_len   = div_active >> 1;
    assign boundary = (cnt == div_active - 1'b1);
    assign load     = (state == S_WAIT) && boundary;

    always_comb begin
        cnt_nxt = boundary ? '0 : cnt + 1'b1;
`ifdef CLK_DIV_SCHED_GATE_EN
        // Parked at the last count, clk_out naturally evaluates low.
        if (boundary && !clk_en) cnt_nxt = cnt;
`endif
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= DIV_W'(DEFAULT_DIV - 1);
            div_active <= DIV_W'(DEFAULT_DIV);
            clk_out    <= 1'b0;
        end else if (load) begin
            div_active <= pend;
`ifdef CLK_DIV_SCHED_GATE_EN
            cnt        <= clk_en ? '0 : pend - 1'b1;
            clk_out    <= clk_en && ((pend >> 1) != '0);
`else
            cnt        <= '0;
            clk_out    <= (pend >> 1) != '0;
`endif
        end else begin
            cnt        <= cnt_nxt;
            clk_out    <= (cnt_nxt < hi_len);
        end
    end

    // ---------------- arbiter ----------------
    // Masking with ack keeps a just-serviced requester from winning again before it drops req.
    assign masked  = bus.req & ~bus.ack;
    assign sel_inc = (sel == IDX_W'(N_REQ - 1)) ? '0 : sel + 1'b1;

    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (masked[(int'(rr_ptr) + k) % N_REQ]) begin
                pick     = IDX_W'((int'(rr_ptr) + k) % N_REQ);
                pick_vld = 1'b1;
            end
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pick_vld) state_nxt = S_GRANT;
            S_GRANT: state_nxt = (pend < DIV_W'(2)) ? S_IDLE : S_WAIT;
            S_WAIT:  if (boundary) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        grant_nxt = bus.grant;
        ack_nxt   = '0;
        err_nxt   = 1'b0;
        pend_nxt  = pend;
        sel_nxt   = sel;
        rr_nxt    = rr_ptr;
        case (state)
            S_IDLE: if (pick_vld) begin
                grant_nxt = ONE << pick;
                pend_nxt  = bus.div_val[int'(pick)*DIV_W +: DIV_W];
                sel_nxt   = pick;
            end
            S_GRANT: if (pend < DIV_W'(2)) begin
                grant_nxt = '0;
                ack_nxt   = ONE << sel;
                err_nxt   = 1'b1;
                rr_nxt    = sel_inc;
            end
            S_WAIT: if (boundary) begin
                grant_nxt = '0;
                ack_nxt   = ONE << sel;
                rr_nxt    = sel_inc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            bus.grant <= '0;
            bus.ack   <= '0;
            bus.err   <= 1'b0;
            pend      <= '0;
            sel       <= '0;
            rr_ptr    <= '0;
        end else begin
            bus.grant <= grant_nxt;
            bus.ack   <= ack_nxt;
            bus.err   <= err_nxt;
            pend      <= pend_nxt;
            sel       <= sel_nxt;
            rr_ptr    <= rr_nxt;
        end
    end

    assign busy = (state != S_IDLE);
endmodule

// File: tb/tb_clk_div_sched.sv
// Directed bench for clk_div_sched: stimulus pushes expected acks, a negedge monitor pops and checks them.
module tb_clk_div_sched;
    localparam int N_REQ = 4;
    localparam int DIV_W = 8;

    typedef struct packed {
        logic [N_REQ-1:0] ack;
        logic             err;
        logic [DIV_W-1:0] div;
    } exp_t;

    logic             clk_in = 1'b0;
    logic             rst_n  = 1'b0;
    logic             busy, clk_out;
    logic [DIV_W-1:0] div_active;
`ifdef CLK_DIV_SCHED_GATE_EN
    logic             clk_en = 1'b1;
`endif

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   oh_bad = 0;
    logic [31:0] c, a, g;

    clk_div_sched_if #(.N_REQ(N_REQ), .DIV_W(DIV_W)) bus ();

    clk_div_sched #(.N_REQ(N_REQ), .DIV_W(DIV_W), .DEFAULT_DIV(3)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
`ifdef CLK_DIV_SCHED_GATE_EN
        .clk_en     (clk_en),
`endif
        .bus        (bus),
        .busy       (busy),
        .div_active (div_active),
        .clk_out    (clk_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input int i, input logic [DIV_W-1:0] v, input logic e, input logic [DIV_W-1:0] d);
        exp_t x;
        x.ack = N_REQ'(1) << i;
        x.err = e;
        x.div = d;
        sb.push_back(x);
        bus.div_val[i*DIV_W +: DIV_W] = v;
        bus.req[i] = 1'b1;
    endtask

    // Steps n cycles; bit k of each mask marks step k. Requesters drop req on seeing ack.
    task automatic run(input int n, output logic [31:0] cb, output logic [31:0] am, output logic [31:0] gm);
        cb = '0; am = '0; gm = '0;
        for (int k = 1; k <= n; k++) begin
            @(negedge clk_in);
            cb = {cb[30:0], clk_out};
            if (|bus.ack) begin
                am[k] = 1'b1;
                bus.req = bus.req & ~bus.ack;
            end
            if (|bus.grant) gm[k] = 1'b1;
            if (!$onehot0(bus.grant) || !$onehot0(bus.ack)) oh_bad++;
        end
    endtask

    always @(negedge clk_in) begin
        if (rst_n && (|bus.ack)) begin
            if (sb.size() == 0) begin
                chk("ack_unexpected", 32'(bus.ack), 0);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_who", 32'(bus.ack), 32'(mon_e.ack));
                chk("ack_err", 32'(bus.err), 32'(mon_e.err));
                chk("ack_div", 32'(div_active), 32'(mon_e.div));
            end
        end
        if (rst_n && bus.err && !(|bus.ack)) chk("err_alone", 32'(bus.err), 0);
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req     = '0;
        bus.div_val = '0;
        repeat (2) @(negedge clk_in);
        chk("rst_clk",   32'(clk_out), 0);
        chk("rst_div",   32'(div_active), 3);
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_ack",   32'(bus.ack), 0);
        chk("rst_err",   32'(bus.err), 0);
        chk("rst_busy",  32'(busy), 0);
        rst_n = 1'b1;

        // Free-running divide-by-3: 1,0,0
        run(6, c, a, g);
        chk("idle_clk",  c, 32'h24);
        chk("idle_ack",  a, 0);
        chk("idle_busy", 32'(busy), 0);
        chk("idle_div",  32'(div_active), 3);

        // Mid-period change to 4, applied at the boundary
        run(1, c, a, g);
        issue(1, 8'd4, 1'b0, 8'd4);
        run(1, c, a, g);
        chk("t2_grant_lat", 32'(bus.grant), 32'h2);
        chk("t2_busy", 32'(busy), 1);
        chk("t2_clk0", c, 0);
        run(9, c, a, g);
        chk("t2_clk",   c, 32'h0CC);
        chk("t2_ackat", a, 32'h4);
        chk("t2_gmask", g, 32'h2);

        // Reset in WAIT discards the pending ratio
        bus.div_val[2*DIV_W +: DIV_W] = 8'd9;
        bus.req[2] = 1'b1;
        run(2, c, a, g);
        chk("t5_gmask", g, 32'h6);
        chk("t5_grant", 32'(bus.grant), 32'h4);
        chk("t5_busy",  32'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_grant", 32'(bus.grant), 0);
        chk("t5_rst_busy",  32'(busy), 0);
        chk("t5_rst_clk",   32'(clk_out), 0);
        chk("t5_rst_div",   32'(div_active), 3);
        chk("t5_rst_ack",   32'(bus.ack), 0);
        bus.req = '0;
        @(negedge clk_in);
        rst_n = 1'b1;
        run(6, c, a, g);
        chk("t5_clk",  c, 32'h24);
        chk("t5_ack",  a, 0);
        chk("t5_gm",   g, 0);
        chk("t5_div",  32'(div_active), 3);

        // Simultaneous requests 0,1,3 with ratios 2,5,7
        issue(0, 8'd2, 1'b0, 8'd2);
        issue(1, 8'd5, 1'b0, 8'd5);
        issue(3, 8'd7, 1'b0, 8'd7);
        run(20, c, a, g);
        chk("t3_clk",   c, 32'h958E1);
        chk("t3_ackat", a, 32'h2110);
        chk("t3_gmask", g, 32'h1EEE);

        // Illegal ratio 1: immediate ack with err, ratio unchanged
        issue(2, 8'd1, 1'b1, 8'd7);
        run(4, c, a, g);
        chk("t4_ackat", a, 32'h4);
        chk("t4_gmask", g, 32'h2);
        chk("t4_div",   32'(div_active), 7);
        chk("t4_busy",  32'(busy), 0);

        run(2, c, a, g);
        chk("onehot",   32'(oh_bad), 0);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
- Programmable clock divider plus the controller that shares it between N_REQ requesters.
- Each requester asks for a new divide ratio (odd or even). A round-robin arbiter picks one request.
- The controller applies the new ratio only at a divider period boundary, so clk_out never shows a runt pulse.
- Sits between the system config/control agents and the generated-clock consumers, one level above the fixed-ratio dividers.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DIV_W, 8, width of each divide-ratio field.
- DEFAULT_DIV, 3, ratio active after reset (2..2^DIV_W-1).

Ports:
- clk_in  input  1  sole clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  N_REQ  per-requester ratio-change request, level.
- div_val  input  N_REQ*DIV_W  requested ratios, requester i at [i*DIV_W +: DIV_W].
- grant  output  N_REQ  one-hot, registered; marks the requester being serviced.
- ack  output  N_REQ  one-cycle completion pulse to the granted requester.
- err  output  1  one-cycle pulse coincident with ack when the ratio was rejected.
- busy  output  1  high in GRANT and WAIT states.
- div_active  output  DIV_W  ratio currently in force.
- clk_out  output  1  divided clock, registered.

Behaviour:
- Reset (async assert, sync release):
  - clk_out=0, cnt=DEFAULT_DIV-1, div_active=DEFAULT_DIV.
  - grant=0, ack=0, err=0, busy=0.
  - state=IDLE, rr pointer=0.
- Divider:
  - cnt counts 0..div_active-1 and wraps to 0.
  - hi_len=div_active>>1; clk_out <= (cnt_next < hi_len).
  - Even N gives 50% duty. Odd N is high floor(N/2) cycles and low ceil(N/2) cycles.
  - Period boundary = cycle where cnt==div_active-1.
  - N=2 gives 1,0,1,0. N=3 gives 1,0,0.
- FSM IDLE -> GRANT -> WAIT -> IDLE.
  - IDLE: if any (req & ~ack) is set, pick the first set index at or after the rr pointer (wrapping).
    - Next edge: grant[i]=1, latch div_val[i] into pend, go to GRANT.
  - GRANT (one cycle): check pend.
    - If pend<2: next edge ack[i]=1, err=1, grant=0, go to IDLE. div_active is unchanged.
    - Otherwise go to WAIT.
  - WAIT: hold until the boundary cycle. On that edge:
    - div_active<=pend, cnt<=0, clk_out<=(0 < pend>>1).
    - ack[i]=1, grant=0, go to IDLE.
  - The rr pointer moves to i+1 (mod N_REQ) on every ack.
- Handshake:
  - Requesters hold req until they see ack, then drop it. The arbiter masks req[i] while ack[i]=1, so one request is never serviced twice.
  - div_val is sampled only at grant; later changes are ignored.
  - Dropping req after grant does not abort; the change still completes and acks.
- Latency:
  - Grant 1 cycle after req.
  - Ack between 2 and div_active+1 cycles after grant.
- Equal-ratio request: still waits for the boundary, then acks. The waveform is unchanged.
- Simultaneous requests: rr order decides; losers keep waiting with req held.
- Reset mid-operation: everything returns to reset values immediately. A pending change is discarded and no ack is issued.

Optional Feature:
- Macro: CLK_DIV_SCHED_GATE_EN.
- Defined: adds input clk_en (1 bit).
  - When clk_en=0, the divider finishes its current period, then holds cnt=div_active-1 and clk_out=0.
  - A held divider counts as at boundary every cycle, so pending changes load immediately.
  - When clk_en=1, counting resumes on the next edge with cnt=0 and clk_out high, if hi_len>0.
- Undefined: port absent; divider free-runs.

Test Plan:
- Reset release, no req -> clk_out repeats 1,0,0 (period 3); div_active=3, busy=0.
- req[1]=1, div_val[1]=4 mid-period -> grant[1] next cycle; ack[1] exactly at the boundary; no clk_out pulse shorter than 1 cycle; afterwards 1,1,0,0.
- req=4'b1011 simultaneously with ratios 2,5,-,7 -> service order 0,1,3; div_active sequence 2,5,7; each ack one cycle, one-hot.
- req[2]=1, div_val=1 -> ack[2] and err high the same cycle, 2 cycles after req; div_active unchanged; no boundary wait.
- rst_n pulled low during WAIT (pend=9) -> outputs at reset values immediately; no ack; after release, ratio is 3.
- GATE_EN build: clk_en=0 mid-high phase -> period completes, clk_out held 0; req ratio 6 acks within 2 cycles of grant; clk_en=1 -> 1,1,1,0,0,0.
